// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] i_dat, input logic i_par);
        return ^{i_dat, i_par};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Latency: 2 clk_in cycles.
// Backpressure: none; free-running.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d_in,
    output logic q_out
);

    logic r_meta;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_meta <= RESET_VAL;
            q_out  <= RESET_VAL;
        end else begin
            r_meta <= d_in;
            q_out  <= r_meta;
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver with E0/F0 prefix handling and idle timeout.
// Latency: strobe one cycle after the synchronized stop-bit falling edge.
// Backpressure: none; the keyboard cannot be stalled, so every strobe must be taken.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] keypress,
    output logic       keypress_valid,
    output logic       keypress_ext,
    output logic       frame_err
);

    localparam int              TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    if (CLK_HZ <= 0) begin : g_invalid_clk_hz
    end

    logic w_ps2_clk;
    logic w_ps2_dat;
    logic w_fall;

    logic            r_ps2_clk_prev;
    ps2_state_t      r_state;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_par_ok;
    logic            r_brk;
    logic            r_ext;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_clk (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     (ps2_clk_in),
        .q_out    (w_ps2_clk)
    );

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_dat (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     (ps2_data_in),
        .q_out    (w_ps2_dat)
    );

    assign w_fall = r_ps2_clk_prev & ~w_ps2_clk;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ps2_clk_prev <= 1'b1;
            r_state        <= IDLE;
            r_shift        <= 8'h00;
            r_bit_cnt      <= 3'd0;
            r_to_cnt       <= '0;
            r_par_ok       <= 1'b0;
            r_brk          <= 1'b0;
            r_ext          <= 1'b0;
            keypress       <= 8'h00;
            keypress_valid <= 1'b0;
            keypress_ext   <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            r_ps2_clk_prev <= w_ps2_clk;
            keypress_valid <= 1'b0;
            frame_err      <= 1'b0;

            if (r_state == IDLE) begin
                r_to_cnt <= '0;
                if (w_fall && !w_ps2_dat) begin
                    r_state   <= DATA;
                    r_bit_cnt <= 3'd0;
                end
            end else if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    DATA: begin
                        r_shift <= {w_ps2_dat, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        r_par_ok <= odd_parity_ok(r_shift, w_ps2_dat);
                        r_state  <= STOP;
                    end
                    default: begin
                        r_state <= IDLE;
                        if (r_par_ok && w_ps2_dat) begin
                            if (r_shift == PS2_EXT) begin
                                r_ext <= 1'b1;
                            end else if (r_shift == PS2_BRK) begin
                                r_brk <= 1'b1;
                            end else if (r_brk) begin
                                // Release code: swallow it along with any prefixes.
                                r_brk <= 1'b0;
                                r_ext <= 1'b0;
                            end else begin
                                keypress       <= r_shift;
                                keypress_ext   <= r_ext;
                                keypress_valid <= 1'b1;
                                r_ext          <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            r_brk     <= 1'b0;
                            r_ext     <= 1'b0;
                        end
                    end
                endcase
            end else if (r_to_cnt == TO_MAX) begin
                r_state   <= IDLE;
                frame_err <= 1'b1;
                r_brk     <= 1'b0;
                r_ext     <= 1'b0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: frames are bit-banged on the PS/2 pins,
// expected strobes are queued as frames are sent and checked as the DUT emits them.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int TO = 200;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic       ext;
        bit         chk_lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] keypress;
    logic       keypress_valid;
    logic       keypress_ext;
    logic       frame_err;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_fall_cyc = 0;
    logic [7:0] last_code = 8'h00;
    logic       last_ext  = 1'b0;

    ps2_keyboard_rx #(.CLK_HZ(100_000_000), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .ps2_clk_in     (ps2_clk),
        .ps2_data_in    (ps2_dat),
        .keypress       (keypress),
        .keypress_valid (keypress_valid),
        .keypress_ext   (keypress_ext),
        .frame_err      (frame_err)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard consumer: every strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (keypress_valid === 1'b1 || frame_err === 1'b1)) begin
            exp_t e;
            n_assert++;
            assert (!(keypress_valid === 1'b1 && frame_err === 1'b1)) else begin
                n_fail++; $error("FAIL both_strobes observed=11 expected=not both");
            end
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++; $error("FAIL unexpected_strobe observed valid=%0b err=%0b expected=no strobe", keypress_valid, frame_err);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_assert++;
                assert (frame_err === e.is_err) else begin
                    n_fail++; $error("FAIL strobe_kind observed err=%0b expected err=%0b", frame_err, e.is_err);
                end
                if (!e.is_err) begin
                    n_assert++;
                    assert (keypress === e.code) else begin
                        n_fail++; $error("FAIL keypress observed=%h expected=%h", keypress, e.code);
                    end
                    n_assert++;
                    assert (keypress_ext === e.ext) else begin
                        n_fail++; $error("FAIL keypress_ext observed=%0b expected=%0b", keypress_ext, e.ext);
                    end
                end
                if (e.chk_lat) begin
                    n_assert++;
                    assert (cyc - last_fall_cyc == 3) else begin
                        n_fail++; $error("FAIL latency observed=%0d expected=3", cyc - last_fall_cyc);
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic d);
        @(negedge clk) ps2_dat = d;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ bad_par);
        send_bit(stop_b);
    endtask

    task automatic expect_key(input logic [7:0] code, input logic ext, input bit lat);
        exp_t e;
        e.is_err = 1'b0; e.code = code; e.ext = ext; e.chk_lat = lat;
        sb.push_back(e);
        last_code = code;
        last_ext  = ext;
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1; e.code = 8'h00; e.ext = 1'b0; e.chk_lat = 1'b0;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        repeat (20) @(negedge clk);
        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++; $error("FAIL %s pending observed=%0d expected=0", tag, sb.size());
            sb.delete();
        end
        n_assert++;
        assert (keypress === last_code && keypress_ext === last_ext) else begin
            n_fail++; $error("FAIL %s hold observed=%h/%0b expected=%h/%0b", tag, keypress, keypress_ext, last_code, last_ext);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_assert++;
        assert (keypress === 8'h00 && keypress_valid === 1'b0 && keypress_ext === 1'b0 && frame_err === 1'b0) else begin
            n_fail++; $error("FAIL %s observed=%h/%0b/%0b/%0b expected=00/0/0/0", tag, keypress, keypress_valid, keypress_ext, frame_err);
        end
        n_assert++;
        assert (dut.r_state === IDLE) else begin
            n_fail++; $error("FAIL %s_state observed=%0d expected=%0d", tag, dut.r_state, IDLE);
        end
    endtask

    initial begin
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic make code with latency check.
        expect_key(8'h1C, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("make_1c");

        // Break sequence is silent and keeps the last code held.
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("break_1c");

        // Extended make, extended break, then plain make clears ext.
        send_frame(8'hE0, 1'b0, 1'b1);
        expect_key(8'h75, 1'b1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1);
        drain("ext_make_75");
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        drain("ext_break_75");
        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("after_ext");

        // Typematic repeat gives one strobe per frame.
        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("typematic");

        // Parity error, then recovery.
        expect_err();
        send_frame(8'h1C, 1'b1, 1'b1);
        drain("parity_err");
        expect_key(8'h32, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b1);
        drain("after_parity");

        // Stop-bit error clears a pending E0 prefix.
        send_frame(8'hE0, 1'b0, 1'b1);
        expect_err();
        send_frame(8'h4B, 1'b0, 1'b0);
        expect_key(8'h4B, 1'b0, 1'b0);
        send_frame(8'h4B, 1'b0, 1'b1);
        drain("stop_err");

        // Timeout mid-frame.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        expect_err();
        repeat (TO + 10) @(negedge clk);
        drain("timeout");
        n_assert++;
        assert (dut.r_state === IDLE) else begin
            n_fail++; $error("FAIL timeout_state observed=%0d expected=%0d", dut.r_state, IDLE);
        end
        expect_key(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b1);
        drain("after_timeout");

        // Reset in the middle of a frame.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        last_code = 8'h00;
        last_ext  = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        drain("mid_reset_quiet");
        expect_key(8'h45, 1'b0, 1'b0);
        send_frame(8'h45, 1'b0, 1'b1);
        drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
